data_ram: RTL and testbench
===========================

# data_ram

Data-memory responder for the CPU's load/store port: it receives the `ram_*` request bundle driven by the MEM stage and serves it from an on-chip word-organised SRAM with byte-lane writes. Writes complete in one cycle. Reads take one extra cycle on the registered SRAM port, and the block holds the pipeline for that cycle with `stallreq_from_mem`, which becomes a new input to `ctrl`. The block sits beside the CPU at top level, on the opposite end of the CPU's data-RAM interface.

## Interface
- `DEPTH_LOG2`, default 10: log2 of the word count. Default is 1024 words (4 KiB).
- `clk  input  1`: single clock; all state updates on the rising edge.
- `rst  input  1`: asynchronous reset, active-high.
- `ram_ce_i  input  1`: request valid (chip enable).
- `ram_we_i  input  1`: 1 = store, 0 = load.
- `ram_sel_i  input  4`: byte-lane enables; bit i enables data[8i+7:8i].
- `ram_addr_i  input  32`: byte address; the word index is addr[DEPTH_LOG2+1:2]; upper bits are ignored.
- `ram_data_i  input  32`: store data, already lane-aligned by MEM.
- `ram_data_o  output  32`: load data (registered).
- `stallreq_from_mem  output  1`: pipeline hold request to `ctrl`.
- `misalign_o  output  1`: illegal-access pulse (see Configuration).

## Operation
- FSM with two states: IDLE and RD. Reset state is IDLE.
- IDLE, ce=0:
  - No action.
  - stall=0.
- IDLE, ce=1, we=1 (store):
  - At the edge, write each lane whose sel bit is 1 into word[addr].
  - Lanes with sel=0 are unchanged.
  - stall=0; stay in IDLE.
- IDLE, ce=1, we=0 (load):
  - stall=1, combinational, in the same cycle.
  - At the edge: latch word[addr] into the ram_data_o register and go to RD.
- RD:
  - stall=0.
  - ram_data_o holds the full 32-bit word. MEM performs lane extraction and sign extension.
  - At the edge, unconditionally return to IDLE.
  - Any ce/we/sel/addr presented in RD is ignored. The pipeline is advancing on this edge, so the next request is seen in IDLE.
- ram_data_o keeps its last loaded value until the next load completes. Stores never modify it.
- There is no read-modify-write. Partial stores rely on the SRAM's per-lane write enables.
- Store followed immediately by a load to the same word: the load returns the stored bytes. The write commits at the edge before the read samples.
- Two consecutive loads: each costs 2 cycles (IDLE→RD→IDLE→RD). No back-to-back shortcut.
- SRAM contents are not reset. Behaviour on reading a never-written word is undefined (X in simulation).

## Timing
- Reset values:
  - state = IDLE
  - ram_data_o = 32'h0
  - stallreq_from_mem = 0
  - misalign_o = 0
- Store latency: 1 cycle, with zero stall cycles.
- Load latency: data is valid in the cycle after the request, with exactly one stall cycle.
- stallreq_from_mem is a combinational function of state, ce and we. It must never be asserted while in RD.
- rst asserted in RD: the block returns to IDLE immediately, with stall=0 and ram_data_o=0. Any store sampled on that edge is discarded.

## Configuration
- Macro: `DATA_RAM_ALIGN_CHK_EN`.
- Legal (sel, addr[1:0]) combinations:
  - sel 4'b1111 with addr[1:0]=00.
  - sel 4'b1100 or 4'b0011 with addr[0]=0.
  - Any one-hot sel, with any address.
- Defined: every request in IDLE with ce=1 is checked against the legal set.
  - An illegal store is suppressed: no lane is written.
  - An illegal load still takes its stall cycle, but the registered data is 32'h0.
  - misalign_o pulses high for exactly one cycle, registered (the cycle after the request).
- Undefined: no check is made and all sel patterns are honoured lane-by-lane. misalign_o is tied 0, but the port remains.

## Structure
- The shared define file gains:
  - `DataMemNum`, `DataMemNumLog2`
  - state encodings `RamIdle`, `RamRd`
  - the existing `ZeroWord`, `ChipEnable`, `WriteEnable` reused
- One sub-module, `ram_bank`:
  - Four 8-bit-wide synchronous SRAM lanes with per-lane write enable and a registered read.
  - Contains no FSM; `data_ram` owns the FSM, stall logic and alignment check.
- Top-level integration:
  - `cpu` gains a `stallreq_from_mem` input.
  - `ctrl` gains a matching input. It stalls PC through MEM and bubbles WB, at the same priority slot as `stallreq_from_ex`.

## Test plan
- Reset:
  - Stimulus: assert rst mid-simulation.
  - Expected: ram_data_o=0, stall=0, misalign_o=0, and the FSM is in IDLE within the same cycle (asynchronous).
- Word store then load:
  - Stimulus: store 32'hDEADBEEF at addr 0x10 with sel=1111, then load 0x10.
  - Expected: no stall for the store. The load asserts stall for 1 cycle, then ram_data_o=32'hDEADBEEF with stall=0.
- Byte-lane store:
  - Stimulus: preload 0x20=32'h11223344, store data 32'hAA000000 with sel=1000, then load 0x20.
  - Expected: 32'hAA223344.
- Back-to-back loads:
  - Stimulus: loads of 0x10 then 0x20 on consecutive requests.
  - Expected: stall pattern 1,0,1,0; data 32'hDEADBEEF, then 32'hAA223344.
- Reset mid-load:
  - Stimulus: issue a load, then assert rst while in RD.
  - Expected: stall=0 and ram_data_o=0 immediately; the next load after reset behaves normally.
- Alignment check, with DATA_RAM_ALIGN_CHK_EN defined:
  - Stimulus: store sel=1111 at addr 0x12.
  - Expected: memory unchanged and misalign_o=1 for one cycle.
  - Same stimulus with the macro undefined: all four lanes of word 0x10 are written.

Source files
------------

// File: rtl/data_ram_pkg.sv
// Shared definitions for the data-memory responder.
// Holds memory sizing, FSM encodings and the alignment rule.
package data_ram_pkg;

  localparam int DataMemNumLog2 = 10;
  localparam int DataMemNum = 1 << DataMemNumLog2;

  localparam logic [31:0] ZeroWord = 32'h0;
  localparam logic ChipEnable = 1'b1;
  localparam logic WriteEnable = 1'b1;

  typedef enum logic {
    RamIdle = 1'b0,
    RamRd   = 1'b1
  } ram_state_e;

  function automatic logic access_legal(
    input logic [3:0] sel,
    input logic [1:0] lo
  );
    logic ok;
    ok = 1'b0;
    if (sel == 4'b1111) begin
      ok = (lo == 2'b00);
    end else if (sel == 4'b1100 || sel == 4'b0011) begin
      ok = ~lo[0];
    end else if (sel != 4'b0000 && (sel & (sel - 4'd1)) == 4'b0000) begin
      ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/data_ram_if.sv
// Load/store bus between the MEM stage and the data RAM.
// master = CPU side, slave = data_ram.
interface data_ram_if;

  logic        ram_ce_i;
  logic        ram_we_i;
  logic [3:0]  ram_sel_i;
  logic [31:0] ram_addr_i;
  logic [31:0] ram_data_i;
  logic [31:0] ram_data_o;
  logic        stallreq_from_mem;
  logic        misalign_o;

  modport master (
    output ram_ce_i,
    output ram_we_i,
    output ram_sel_i,
    output ram_addr_i,
    output ram_data_i,
    input  ram_data_o,
    input  stallreq_from_mem,
    input  misalign_o
  );

  modport slave (
    input  ram_ce_i,
    input  ram_we_i,
    input  ram_sel_i,
    input  ram_addr_i,
    input  ram_data_i,
    output ram_data_o,
    output stallreq_from_mem,
    output misalign_o
  );

endinterface

// File: rtl/data_ram_bank.sv
// Four byte-wide synchronous SRAM lanes, per-lane write
// enable, shared registered read port (ram_bank).
module ram_bank #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            we_i,
  input  logic                  re_i,
  input  logic                  zero_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  localparam int Words = 1 << DEPTH_LOG2;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] mem_q [Words];
    logic [7:0] rd_q;

    always_ff @(posedge clk) begin
      if (we_i[i]) begin
        mem_q[addr_i] <= wdata_i[8*i +: 8];
      end
    end

    // Read register holds until the next accepted load
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_q <= 8'h00;
      end else if (re_i) begin
        rd_q <= zero_i ? 8'h00 : mem_q[addr_i];
      end
    end

    assign rdata_o[8*i +: 8] = rd_q;
  end

endmodule

// File: rtl/data_ram.sv
// Data RAM responder: 1-cycle stores, loads with one stall cycle.
// Optional access check enabled by DATA_RAM_ALIGN_CHK_EN.
module data_ram
  import data_ram_pkg::*;
#(
  parameter int DEPTH_LOG2 = DataMemNumLog2
) (
  input logic         clk,
  input logic         rst,
  data_ram_if.slave   bus
);

  ram_state_e state_q;

  logic       req;
  logic       is_st;
  logic       is_ld;
  logic       legal;
  logic [3:0] lane_we;
  logic       unused_addr;

  assign req   = (state_q == RamIdle) && (bus.ram_ce_i == ChipEnable);
  assign is_st = req && (bus.ram_we_i == WriteEnable);
  assign is_ld = req && (bus.ram_we_i != WriteEnable);

`ifdef DATA_RAM_ALIGN_CHK_EN
  logic misalign_q;

  assign legal = access_legal(bus.ram_sel_i, bus.ram_addr_i[1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= req && !legal;
    end
  end

  assign bus.misalign_o = misalign_q;
`else
  assign legal = 1'b1;
  assign bus.misalign_o = 1'b0;
`endif

  // A store coinciding with a reset edge must not land in the array
  assign lane_we = (is_st && legal && !rst) ? bus.ram_sel_i : 4'b0000;

  assign bus.stallreq_from_mem = is_ld;

  assign unused_addr = ^{bus.ram_addr_i[31:DEPTH_LOG2+2],
                         bus.ram_addr_i[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RamIdle;
    end else begin
      unique case (state_q)
        RamIdle: state_q <= is_ld ? RamRd : RamIdle;
        RamRd:   state_q <= RamIdle;
        default: state_q <= RamIdle;
      endcase
    end
  end

  ram_bank #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_bank (
    .clk    (clk),
    .rst    (rst),
    .we_i   (lane_we),
    .re_i   (is_ld),
    .zero_i (!legal),
    .addr_i (bus.ram_addr_i[DEPTH_LOG2+1:2]),
    .wdata_i(bus.ram_data_i),
    .rdata_o(bus.ram_data_o)
  );

endmodule

// File: tb/tb_data_ram.sv
// Directed bench for data_ram: stores, loads, stall timing,
// reset during a load and the optional access check.
module tb_data_ram;
  import data_ram_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  data_ram_if bus ();

  data_ram dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic ce, input logic we,
                       input logic [3:0] sel,
                       input logic [31:0] addr,
                       input logic [31:0] data);
    bus.ram_ce_i   = ce;
    bus.ram_we_i   = we;
    bus.ram_sel_i  = sel;
    bus.ram_addr_i = addr;
    bus.ram_data_i = data;
  endtask

  task automatic do_idle();
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic do_store(input logic [31:0] addr,
                          input logic [3:0] sel,
                          input logic [31:0] data);
    @(negedge clk);
    drive(1'b1, 1'b1, sel, addr, data);
    #1;
    n_chk++;
    if (bus.stallreq_from_mem !== 1'b0) begin
      n_fail++;
      $display("FAIL store_stall addr=%h got=%b exp=0", addr,
               bus.stallreq_from_mem);
    end
  endtask

  task automatic do_load(input logic [31:0] addr,
                         input logic [31:0] exp);
    @(negedge clk);
    drive(1'b1, 1'b0, 4'hF, addr, 32'h0);
    #1;
    n_chk++;
    if (bus.stallreq_from_mem !== 1'b1) begin
      n_fail++;
      $display("FAIL load_stall addr=%h got=%b exp=1", addr,
               bus.stallreq_from_mem);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    n_chk++;
    if (bus.stallreq_from_mem !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_stall addr=%h got=%b exp=0", addr,
               bus.stallreq_from_mem);
    end
    n_chk++;
    if (bus.ram_data_o !== exp) begin
      n_fail++;
      $display("FAIL load_data addr=%h got=%h exp=%h", addr,
               bus.ram_data_o, exp);
    end
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    rst = 1'b1;
    #1;
    n_chk++;
    if (bus.ram_data_o !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_data got=%h exp=0", bus.ram_data_o);
    end
    n_chk++;
    if (bus.stallreq_from_mem !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_stall got=%b exp=0", bus.stallreq_from_mem);
    end
    n_chk++;
    if (bus.misalign_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_misalign got=%b exp=0", bus.misalign_o);
    end
    n_chk++;
    if (dut.state_q !== RamIdle) begin
      n_fail++;
      $display("FAIL rst_state got=%b exp=0", dut.state_q);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_word();
    do_store(32'h10, 4'hF, 32'hDEADBEEF);
    do_load(32'h10, 32'hDEADBEEF);
  endtask

  task automatic test_byte_lane();
    do_store(32'h20, 4'hF, 32'h11223344);
    do_store(32'h20, 4'b1000, 32'hAA000000);
    do_idle();
    #1;
    n_chk++;
    if (bus.ram_data_o !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL data_hold got=%h exp=deadbeef", bus.ram_data_o);
    end
    do_load(32'h20, 32'hAA223344);
  endtask

  task automatic test_store_then_load();
    do_store(32'h30, 4'hF, 32'h12345678);
    do_load(32'h30, 32'h12345678);
    do_store(32'h31, 4'b0010, 32'h0000CD00);
    do_load(32'h30, 32'h1234CD78);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive(1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    #1;
    n_chk++;
    if (bus.stallreq_from_mem !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_stall0 got=%b exp=1", bus.stallreq_from_mem);
    end
    @(negedge clk);
    drive(1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
    #1;
    n_chk++;
    if (bus.stallreq_from_mem !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_stall1 got=%b exp=0", bus.stallreq_from_mem);
    end
    n_chk++;
    if (bus.ram_data_o !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL b2b_data0 got=%h exp=deadbeef", bus.ram_data_o);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (bus.stallreq_from_mem !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_stall2 got=%b exp=1", bus.stallreq_from_mem);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    n_chk++;
    if (bus.stallreq_from_mem !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_stall3 got=%b exp=0", bus.stallreq_from_mem);
    end
    n_chk++;
    if (bus.ram_data_o !== 32'hAA223344) begin
      n_fail++;
      $display("FAIL b2b_data1 got=%h exp=aa223344", bus.ram_data_o);
    end
  endtask

  task automatic test_reset_mid_load();
    @(negedge clk);
    drive(1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    @(negedge clk);
    drive(1'b1, 1'b1, 4'hF, 32'h20, 32'hFFFFFFFF);
    #1;
    n_chk++;
    if (dut.state_q !== RamRd) begin
      n_fail++;
      $display("FAIL mid_state_rd got=%b exp=1", dut.state_q);
    end
    #2;
    rst = 1'b1;
    #1;
    n_chk++;
    if (bus.stallreq_from_mem !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_stall got=%b exp=0", bus.stallreq_from_mem);
    end
    n_chk++;
    if (bus.ram_data_o !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_rst_data got=%h exp=0", bus.ram_data_o);
    end
    n_chk++;
    if (dut.state_q !== RamIdle) begin
      n_fail++;
      $display("FAIL mid_rst_state got=%b exp=0", dut.state_q);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    do_load(32'h20, 32'hAA223344);
    do_load(32'h10, 32'hDEADBEEF);
  endtask

  task automatic test_align();
    do_store(32'h12, 4'hF, 32'h55667788);
    do_idle();
    #1;
`ifdef DATA_RAM_ALIGN_CHK_EN
    n_chk++;
    if (bus.misalign_o !== 1'b1) begin
      n_fail++;
      $display("FAIL mis_st_pulse got=%b exp=1", bus.misalign_o);
    end
    do_idle();
    #1;
    n_chk++;
    if (bus.misalign_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_st_clear got=%b exp=0", bus.misalign_o);
    end
    do_load(32'h10, 32'hDEADBEEF);
    do_load(32'h11, 32'h0);
    n_chk++;
    if (bus.misalign_o !== 1'b1) begin
      n_fail++;
      $display("FAIL mis_ld_pulse got=%b exp=1", bus.misalign_o);
    end
    do_idle();
    #1;
    n_chk++;
    if (bus.misalign_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_ld_clear got=%b exp=0", bus.misalign_o);
    end
`else
    n_chk++;
    if (bus.misalign_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_tied got=%b exp=0", bus.misalign_o);
    end
    do_load(32'h10, 32'h55667788);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_word();
    test_byte_lane();
    test_store_then_load();
    test_back_to_back();
    test_reset_mid_load();
    test_align();
    do_idle();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
